cpu_run_monitor: RTL

Run controller and end-of-program monitor for the single-cycle MIPS core. It sequences the core's reset after a start request and counts executed cycles. It detects program completion by a store to a magic address, a PC self-loop, or a cycle timeout, and reports a latched status. It sits between the simulation/board top level and `single_cycle_CPU`, replacing hand-timed reset pulses and open-ended runs.

---
 rtl/cpu_run_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller and end-of-program monitor for the
// single-cycle MIPS core. It holds the core in reset for a fixed number of
// cycles after a start request, then lets it run while counting cycles.
// A run ends on a store to the magic done address, on a PC self-loop or on
// a cycle timeout. The outcome is latched until the next start or reset.
module cpu_run_monitor #(
  parameter int unsigned              RESET_CYCLES   = 2,
  parameter int unsigned              TIMEOUT_CYCLES = 5000,
  parameter int unsigned              STALL_LIMIT    = 4,
  parameter int unsigned              ADDR_W         = 32,
  parameter int unsigned              DATA_W         = 32,
  parameter logic [ADDR_W-1:0]        DONE_ADDR      = 'h0000_00FC,
  parameter logic [DATA_W-1:0]        PASS_VALUE     = 'd1,
  parameter int unsigned              CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] result
);

  // Counter widths sized so each counter can hold its own terminal value.
  localparam int RST_W   = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_HALT    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    RUN,
    DONE
  } state_e;

  state_e              state_q;
  logic                cpuReset_q;
  logic                running_q;
  logic                done_q;
  logic [2:0]          status_q;
  logic [CNT_W-1:0]    cycleCount_q;
  logic [DATA_W-1:0]   result_q;
  logic [RST_W-1:0]    rstCnt_q;
  logic [STALL_W-1:0]  stallCnt_q;
  logic [ADDR_W-1:0]   prevPc_q;
  logic                pcValid_q;

  logic [CNT_W-1:0]    cycleCount_d;
  logic [RST_W-1:0]    rstCnt_d;
  logic [STALL_W-1:0]  stallCnt_d;
  logic [2:0]          status_d;
  logic                storeHit;
  logic                haltHit;
  logic                timeoutHit;
  logic                terminate;

  // Next counter values and the prioritised termination verdict for a RUN cycle.
  always_comb begin
    cycleCount_d = (&cycleCount_q) ? cycleCount_q : cycleCount_q + CNT_W'(1);
    rstCnt_d     = rstCnt_q + RST_W'(1);
    stallCnt_d   = (pcValid_q && (pc == prevPc_q)) ? stallCnt_q + STALL_W'(1) : '0;
    storeHit     = mem_we && (mem_addr == DONE_ADDR);
    haltHit      = (stallCnt_d == STALL_W'(STALL_LIMIT));
    timeoutHit   = (cycleCount_d == CNT_W'(TIMEOUT_CYCLES));
    status_d     = ST_NONE;
    if (storeHit) begin
      status_d = (mem_wdata == PASS_VALUE) ? ST_PASS : ST_FAIL;
    end else if (haltHit) begin
      status_d = ST_HALT;
    end else if (timeoutHit) begin
      status_d = ST_TIMEOUT;
    end
    terminate = (status_d != ST_NONE);
  end

  // Run-control state machine; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cpuReset_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= ST_NONE;
      cycleCount_q <= '0;
      result_q     <= '0;
      rstCnt_q     <= '0;
      stallCnt_q   <= '0;
      prevPc_q     <= '0;
      pcValid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cpuReset_q <= 1'b1;
          running_q  <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            state_q      <= RST;
            rstCnt_q     <= '0;
            cycleCount_q <= '0;
            status_q     <= ST_NONE;
            result_q     <= '0;
          end
        end

        RST: begin
          cpuReset_q <= 1'b1;
          if (rstCnt_q == RST_W'(RESET_CYCLES)) begin
            state_q    <= RUN;
            cpuReset_q <= 1'b0;
            running_q  <= 1'b1;
            pcValid_q  <= 1'b0;
            stallCnt_q <= '0;
          end else begin
            rstCnt_q <= rstCnt_d;
          end
        end

        RUN: begin
          cycleCount_q <= cycleCount_d;
          prevPc_q     <= pc;
          pcValid_q    <= 1'b1;
          stallCnt_q   <= stallCnt_d;
          if (terminate) begin
            state_q    <= DONE;
            status_q   <= status_d;
            cpuReset_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
            if (storeHit) begin
              result_q <= mem_wdata;
            end
          end
        end

        DONE: begin
          cpuReset_q <= 1'b1;
          running_q  <= 1'b0;
          if (start) begin
            state_q      <= RST;
            rstCnt_q     <= '0;
            done_q       <= 1'b0;
            status_q     <= ST_NONE;
            result_q     <= '0;
            cycleCount_q <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_reset   = cpuReset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = cycleCount_q;
  assign result      = result_q;

endmodule
